// File: rtl/dma_write_feeder.sv
`default_nettype none
// dma_write_feeder (rev 1.0): word FIFO plus command FSM that feeds the byte-aligning DMA write path,
// raising dma_start only once enough of the transfer is buffered.
module dma_write_feeder #(
  parameter int AXI_ADDR_W = 32,
  parameter int LEN_W      = 16,
  parameter int DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AXI_ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [31:0]             s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [AXI_ADDR_W-1:0]   dma_addr,
  output logic [LEN_W-1:0]        dma_length,
  output logic                    dma_read_not_write,
  output logic                    dma_start,
  input  logic                    dma_ready,
  output logic [31:0]             dma_data_in,
  input  logic                    dma_ready_in,
  output logic                    busy,
  output logic                    done,
  output logic                    underflow,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CMP_W = (LEN_W > PTR_W + 1) ? LEN_W : PTR_W + 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_START = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  state_t                  state_q;
  logic [31:0]             mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]          count_q, count_d;
  logic [LEN_W-1:0]        words_left_q, words_left_d;
  logic [AXI_ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]        len_q;
  logic                    dma_start_q, done_q, underflow_q;

  logic full, empty, push, pop, beat, accept, fill_ok;
  logic [LEN_W-1:0] len_words;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign push      = s_valid & ~full;
  // A DMA beat only counts while words remain; extra beats on misaligned transfers are ignored.
  assign beat      = dma_ready_in & (words_left_q != '0);
  assign pop       = beat & ~empty;
  assign cmd_ready = (state_q == S_IDLE) & dma_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign len_words = LEN_W'(cmd_len[LEN_W-1:2]) + LEN_W'(|cmd_len[1:0]);
  assign fill_ok   = (CMP_W'(count_q) >= CMP_W'(words_left_q)) || full;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  always_comb begin
    words_left_d = words_left_q;
    if (accept) begin
      words_left_d = len_words;
    end else if (beat) begin
      words_left_d = words_left_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      words_left_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q      <= count_d;
      words_left_q <= words_left_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      dma_start_q <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      dma_start_q <= 1'b0;
      done_q      <= 1'b0;
      if (beat && empty) underflow_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q      <= cmd_addr;
            len_q       <= cmd_len;
            underflow_q <= 1'b0;
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (fill_ok) begin
            state_q     <= S_START;
            dma_start_q <= 1'b1;
          end
        end
        S_START: state_q <= S_RUN;
        S_RUN: begin
          if (dma_ready) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dma_data_in        = empty ? 32'd0 : mem_q[rd_ptr_q];
  assign dma_addr           = addr_q;
  assign dma_length         = len_q;
  assign dma_read_not_write = 1'b0;
  assign dma_start          = dma_start_q;
  assign done               = done_q;
  assign underflow          = underflow_q;
  assign busy               = (state_q != S_IDLE);
  assign s_ready            = ~full;
  assign level              = count_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_write_feeder.sv
`default_nettype none
// tb_dma_write_feeder: scenario tasks against a queue-based model of the feeder's FIFO and word accounting.
module tb_dma_write_feeder;
  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_valid, cmd_ready;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic [31:0] dma_addr;
  logic [15:0] dma_length;
  logic        dma_read_not_write, dma_start, dma_ready;
  logic [31:0] dma_data_in;
  logic        dma_ready_in, busy, done, underflow;
  logic [LVL_W-1:0] level;

  dma_write_feeder #(.AXI_ADDR_W(32), .LEN_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dma_addr(dma_addr), .dma_length(dma_length), .dma_read_not_write(dma_read_not_write),
    .dma_start(dma_start), .dma_ready(dma_ready), .dma_data_in(dma_data_in),
    .dma_ready_in(dma_ready_in), .busy(busy), .done(done), .underflow(underflow), .level(level)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] mq[$];
  int          m_wl = 0;
  bit          m_uf = 1'b0;

  function automatic logic [31:0] head();
    if (mq.size() == 0) return 32'h0;
    return mq[0];
  endfunction

  // One clock: the model applies the push/pop/underflow rules to the inputs present at the edge.
  task automatic step();
    bit do_push, do_pop;
    logic [31:0] d;
    d       = s_data;
    do_push = s_valid && (mq.size() < DEPTH);
    do_pop  = dma_ready_in && (m_wl != 0) && (mq.size() != 0);
    if (dma_ready_in && m_wl != 0 && mq.size() == 0) m_uf = 1'b1;
    if (dma_ready_in && m_wl != 0) m_wl--;
    @(posedge clk);
    #1;
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(d);
    if (s_valid) s_data = $urandom;
  endtask

  task automatic issue(input logic [31:0] a, input logic [15:0] l, output bit rdy);
    cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    rdy = cmd_ready;
    step();
    cmd_valid = 1'b0;
    if (rdy) begin
      m_wl = (int'(l) + 3) / 4;
      m_uf = 1'b0;
    end
  endtask

  // lat counts cycles from the accept cycle to the cycle showing dma_start; -1 on timeout.
  task automatic wait_start(output int lat);
    lat = 1;
    while (dma_start !== 1'b1 && lat < 300) begin
      step();
      lat++;
    end
    if (dma_start !== 1'b1) lat = -1;
  endtask

  task automatic finish_cmd();
    dma_ready_in = 1'b0;
    dma_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, done, dma_start, underflow, dma_read_not_write} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {busy, done, dma_start, underflow, dma_read_not_write}); else passed++;
    checks++; if (level !== LVL_W'(0) || s_ready !== 1'b1) $display("FAIL reset_fifo: level %0d s_ready %b want 0 1", level, s_ready); else passed++;
    checks++; if ({dma_addr, dma_length, dma_data_in} !== 80'h0) $display("FAIL reset_data: got %h want 0", {dma_addr, dma_length, dma_data_in}); else passed++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else passed++;
    rst = 1'b0;
    mq.delete(); m_wl = 0; m_uf = 1'b0;
  endtask

  task automatic test_aligned();
    int lat; bit rdy; logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      step();
    end
    s_valid = 1'b0;
    checks++; if (level !== LVL_W'(4)) $display("FAIL prefill_level: got %0d want 4", level); else passed++;
    issue(32'h1000, 16'd16, rdy);
    checks++; if (rdy !== 1'b1) $display("FAIL aligned_accept: cmd_ready %b want 1", rdy); else passed++;
    wait_start(lat);
    checks++; if (lat != 2) $display("FAIL aligned_latency: got %0d want 2", lat); else passed++;
    checks++; if (dma_addr !== 32'h1000 || dma_length !== 16'd16 || busy !== 1'b1) $display("FAIL aligned_cmd: addr %h len %0d busy %b want 1000 16 1", dma_addr, dma_length, busy); else passed++;
    dma_ready = 1'b0;
    step();
    checks++; if (dma_start !== 1'b0) $display("FAIL start_pulse_width: got %b want 0", dma_start); else passed++;
    dma_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      checks++; if (dma_data_in !== w) $display("FAIL aligned_word%0d: got %h want %h", i, dma_data_in, w); else passed++;
      step();
    end
    finish_cmd();
    checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL aligned_done: done %b busy %b want 1 0", done, busy); else passed++;
    checks++; if (level !== LVL_W'(0) || underflow !== 1'b0) $display("FAIL aligned_end: level %0d underflow %b want 0 0", level, underflow); else passed++;
    step();
    checks++; if (done !== 1'b0) $display("FAIL done_pulse_width: got %b want 0", done); else passed++;
  endtask

  task automatic test_zero_len();
    bit rdy;
    issue(32'h2000, 16'd0, rdy);
    checks++; if (rdy !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || dma_start !== 1'b0) $display("FAIL zero_len: rdy %b done %b busy %b start %b want 1 1 0 0", rdy, done, busy, dma_start); else passed++;
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || dma_start !== 1'b0) $display("FAIL zero_len_after: done %b busy %b start %b want 0 0 0", done, busy, dma_start); else passed++;
  endtask

  task automatic test_misaligned();
    int lat; bit rdy;
    s_valid = 1'b1; s_data = $urandom;
    repeat (2) step();
    s_valid = 1'b0;
    issue(32'h1001, 16'd7, rdy);
    wait_start(lat);
    checks++; if (lat != 2) $display("FAIL misaligned_latency: got %0d want 2", lat); else passed++;
    dma_ready = 1'b0;
    step();
    dma_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (dma_data_in !== head()) $display("FAIL misaligned_beat%0d: got %h want %h", i, dma_data_in, head()); else passed++;
      step();
    end
    dma_ready_in = 1'b0;
    checks++; if (level !== LVL_W'(0) || underflow !== 1'b0) $display("FAIL misaligned_end: level %0d underflow %b want 0 0", level, underflow); else passed++;
    finish_cmd();
    checks++; if (done !== 1'b1) $display("FAIL misaligned_done: got %b want 1", done); else passed++;
  endtask

  task automatic test_full();
    int lat; bit rdy;
    s_valid = 1'b1; s_data = $urandom;
    repeat (DEPTH + 2) step();
    checks++; if (level !== LVL_W'(DEPTH) || s_ready !== 1'b0) $display("FAIL full_level: level %0d s_ready %b want %0d 0", level, s_ready, DEPTH); else passed++;
    issue(32'h3000, 16'(4*DEPTH), rdy);
    wait_start(lat);
    checks++; if (lat != 2) $display("FAIL full_latency: got %0d want 2", lat); else passed++;
    dma_ready = 1'b0;
    step();
    dma_ready_in = 1'b1;
    step();
    checks++; if (level !== LVL_W'(DEPTH - 1)) $display("FAIL push_refused_on_pop: level %0d want %0d", level, DEPTH - 1); else passed++;
    s_valid = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      checks++; if (dma_data_in !== head()) $display("FAIL full_drain%0d: got %h want %h", i, dma_data_in, head()); else passed++;
      step();
    end
    finish_cmd();
    checks++; if (done !== 1'b1 || level !== LVL_W'(0)) $display("FAIL full_done: done %b level %0d want 1 0", done, level); else passed++;
  endtask

  task automatic test_underflow();
    int lat; bit rdy; bit early;
    early = 1'b0;
    issue(32'h4000, 16'(4*DEPTH + 8), rdy);
    s_valid = 1'b1; s_data = $urandom;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      if (dma_start === 1'b1) early = 1'b1;
    end
    s_valid = 1'b0;
    checks++; if (early) $display("FAIL start_before_fill: got 1 want 0"); else passed++;
    wait_start(lat);
    checks++; if (lat < 0 || level !== LVL_W'(DEPTH)) $display("FAIL long_start: lat %0d level %0d want start at level %0d", lat, level, DEPTH); else passed++;
    dma_ready = 1'b0;
    step();
    dma_ready_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (dma_data_in !== head()) $display("FAIL long_word%0d: got %h want %h", i, dma_data_in, head()); else passed++;
      step();
    end
    checks++; if (underflow !== 1'b0 || dma_data_in !== 32'h0) $display("FAIL pre_underflow: underflow %b data %h want 0 0", underflow, dma_data_in); else passed++;
    step();
    checks++; if (underflow !== 1'b1 || level !== LVL_W'(0)) $display("FAIL underflow_set: underflow %b level %0d want 1 0", underflow, level); else passed++;
    step();
    finish_cmd();
    checks++; if (done !== 1'b1 || underflow !== 1'b1) $display("FAIL underflow_sticky: done %b underflow %b want 1 1", done, underflow); else passed++;
    issue(32'h5000, 16'd0, rdy);
    checks++; if (underflow !== 1'b0) $display("FAIL underflow_clear: got %b want 0", underflow); else passed++;
  endtask

  task automatic test_reset_mid_run();
    int lat; bit rdy;
    s_valid = 1'b1; s_data = $urandom;
    repeat (3) step();
    s_valid = 1'b0;
    issue(32'h6000, 16'd12, rdy);
    wait_start(lat);
    dma_ready = 1'b0;
    step();
    dma_ready_in = 1'b1;
    step();
    dma_ready_in = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checks++; if ({busy, done, dma_start, underflow, level} !== 8'h0) $display("FAIL async_reset_flags: got %h want 0", {busy, done, dma_start, underflow, level}); else passed++;
    checks++; if ({dma_addr, dma_length, dma_data_in} !== 80'h0) $display("FAIL async_reset_data: got %h want 0", {dma_addr, dma_length, dma_data_in}); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete(); m_wl = 0; m_uf = 1'b0;
    dma_ready = 1'b1;
    s_valid = 1'b1; s_data = $urandom;
    repeat (2) step();
    s_valid = 1'b0;
    issue(32'h7000, 16'd8, rdy);
    wait_start(lat);
    checks++; if (lat != 2 || dma_addr !== 32'h7000) $display("FAIL post_reset_start: lat %0d addr %h want 2 7000", lat, dma_addr); else passed++;
    dma_ready = 1'b0;
    step();
    dma_ready_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (dma_data_in !== head()) $display("FAIL post_reset_word%0d: got %h want %h", i, dma_data_in, head()); else passed++;
      step();
    end
    finish_cmd();
    checks++; if (done !== 1'b1 || level !== LVL_W'(0)) $display("FAIL post_reset_done: done %b level %0d want 1 0", done, level); else passed++;
  endtask

  task automatic test_random();
    int lat; bit rdy; int len; int n;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(0, 4*DEPTH + 3);
      s_valid = 1'b0;
      issue($urandom, 16'(len), rdy);
      checks++; if (rdy !== 1'b1) $display("FAIL rand%0d_accept: got %b want 1", it, rdy); else passed++;
      if (len == 0) begin
        checks++; if (done !== 1'b1) $display("FAIL rand%0d_zero_done: got %b want 1", it, done); else passed++;
        step();
        continue;
      end
      s_valid = 1'b1; s_data = $urandom;
      wait_start(lat);
      checks++; if (lat < 2) $display("FAIL rand%0d_start: lat %0d want >= 2", it, lat); else passed++;
      dma_ready = 1'b0;
      step();
      n = 0;
      while (m_wl != 0 && n < 400) begin
        dma_ready_in = ($urandom_range(0, 9) < 7);
        s_valid = $urandom_range(0, 1) == 1;
        checks++; if (dma_data_in !== head() || level !== LVL_W'(mq.size())) $display("FAIL rand%0d_beat%0d: data %h level %0d want %h %0d", it, n, dma_data_in, level, head(), mq.size()); else passed++;
        step();
        n++;
      end
      checks++; if (m_wl != 0) $display("FAIL rand%0d_timeout: words left %0d want 0", it, m_wl); else passed++;
      s_valid = 1'b0;
      dma_ready_in = 1'b1;
      repeat (2) step();
      checks++; if (level !== LVL_W'(mq.size()) || underflow !== m_uf) $display("FAIL rand%0d_extra_beats: level %0d underflow %b want %0d %b", it, level, underflow, mq.size(), m_uf); else passed++;
      finish_cmd();
      checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL rand%0d_done: done %b busy %b want 1 0", it, done, busy); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1; cmd_addr = '0; cmd_len = '0; cmd_valid = 1'b0;
    s_data = '0; s_valid = 1'b0; dma_ready = 1'b1; dma_ready_in = 1'b0;
    test_reset();
    test_aligned();
    test_zero_len();
    test_misaligned();
    test_full();
    test_underflow();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1);
  end
endmodule
`default_nettype wire
